// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, data-memory wait freeze,
// taken-branch IF/ID flush, and a saturating stall-cycle performance counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [4:0]        IDEX_RTaddr_i,
    input  logic [4:0]        IFID_RSaddr_i,
    input  logic [4:0]        IFID_RTaddr_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              PC_hold_o,
    output logic              IFID_hold_o,
    output logic              IFID_flush_o,
    output logic              IDEX_hold_o,
    output logic              IDEX_bubble_o,
    output logic              EXMEM_hold_o,
    output logic              MEMWB_bubble_o,
    output logic              err_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              pend_flush_q, pend_flush_d;
    logic              err_q, err_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu;
    logic miss;
    logic timeout_hit;

    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;

    assign lu = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));
    assign miss = dmem_req_i && !dmem_ack_i;

    // Forced release on the last allowed wait cycle keeps a dead memory from hanging the core.
    assign timeout_hit = (state_q == StMemWait) && !dmem_ack_i && (to_cnt_q == ToLast);

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        pend_flush_d = pend_flush_q;
        err_d        = err_q;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;

        case (state_q)
            StRun: begin
                if (miss) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                    state_d      = StMemWait;
                    to_cnt_d     = '0;
                    // A branch taken while frozen is flushed on the release cycle.
                    pend_flush_d = branch_taken_i;
                end else if (lu) begin
                    // Branch operands are not yet resolved; ID re-evaluates it next cycle.
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end else if (branch_taken_i) begin
                    ifid_flush = 1'b1;
                end
            end
            StMemWait: begin
                if (dmem_ack_i || timeout_hit) begin
                    ifid_flush   = pend_flush_q;
                    pend_flush_d = 1'b0;
                    state_d      = StRun;
                    if (timeout_hit) begin
                        err_d = 1'b1;
                    end
                end else begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                    to_cnt_d     = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_hold && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StRun;
            to_cnt_q     <= '0;
            pend_flush_q <= 1'b0;
            err_q        <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            pend_flush_q <= pend_flush_d;
            err_q        <= err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Combinational controls are forced low for as long as reset is held.
    assign PC_hold_o      = pc_hold && rst_i;
    assign IFID_hold_o    = ifid_hold && rst_i;
    assign IFID_flush_o   = ifid_flush && rst_i;
    assign IDEX_hold_o    = idex_hold && rst_i;
    assign IDEX_bubble_o  = idex_bubble && rst_i;
    assign EXMEM_hold_o   = exmem_hold && rst_i;
    assign MEMWB_bubble_o = memwb_bubble && rst_i;
    assign err_o          = err_q;
    assign stall_cnt_o    = stall_cnt_q;

    bubble_hold_exclusive_a: assert property (
        @(posedge clk_i) disable iff (!rst_i) !(IDEX_bubble_o && IDEX_hold_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a behavioural model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned TO_W    = 3;
    localparam int unsigned PERF_W  = 4;
    localparam int          SatMax  = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              IDEX_MemRead_i = 1'b0;
    logic [4:0]        IDEX_RTaddr_i = 5'd0;
    logic [4:0]        IFID_RSaddr_i = 5'd0;
    logic [4:0]        IFID_RTaddr_i = 5'd0;
    logic              branch_taken_i = 1'b0;
    logic              dmem_req_i = 1'b0;
    logic              dmem_ack_i = 1'b0;
    logic              PC_hold_o, IFID_hold_o, IFID_flush_o, IDEX_hold_o;
    logic              IDEX_bubble_o, EXMEM_hold_o, MEMWB_bubble_o, err_o;
    logic [PERF_W-1:0] stall_cnt_o;

    pipeline_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W),
        .PERF_W  (PERF_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_RTaddr_i  (IDEX_RTaddr_i),
        .IFID_RSaddr_i  (IFID_RSaddr_i),
        .IFID_RTaddr_i  (IFID_RTaddr_i),
        .branch_taken_i (branch_taken_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ack_i     (dmem_ack_i),
        .PC_hold_o      (PC_hold_o),
        .IFID_hold_o    (IFID_hold_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_hold_o    (IDEX_hold_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .EXMEM_hold_o   (EXMEM_hold_o),
        .MEMWB_bubble_o (MEMWB_bubble_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Output vector order: {PC_hold, IFID_hold, IFID_flush, IDEX_hold, IDEX_bubble, EXMEM_hold, MEMWB_bubble}
    localparam logic [6:0] VecFreeze = 7'b1101011;
    localparam logic [6:0] VecLoadUse = 7'b1100100;
    localparam logic [6:0] VecFlush = 7'b0010000;

    logic [6:0] dut_vec;
    assign dut_vec = {PC_hold_o, IFID_hold_o, IFID_flush_o, IDEX_hold_o,
                      IDEX_bubble_o, EXMEM_hold_o, MEMWB_bubble_o};

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model state: "waiting" = a memory access is outstanding, "waited" = wait cycles so far.
    logic m_wait = 1'b0;
    int   m_waited = 0;
    logic m_pend = 1'b0;
    logic m_err = 1'b0;
    int   m_stall = 0;

    typedef struct packed {
        logic [6:0] vec;
        logic       release_now;
        logic       timed_out;
        logic       miss;
    } exp_t;

    function automatic exp_t model_eval();
        exp_t e;
        logic lu;
        e = '0;
        lu = IDEX_MemRead_i && IDEX_RTaddr_i != 0 &&
             (IDEX_RTaddr_i == IFID_RSaddr_i || IDEX_RTaddr_i == IFID_RTaddr_i);
        e.miss = dmem_req_i && !dmem_ack_i;
        if (rst_i) begin
            if (!m_wait) begin
                if (e.miss) e.vec = VecFreeze;
                else if (lu) e.vec = VecLoadUse;
                else if (branch_taken_i) e.vec = VecFlush;
            end else begin
                e.timed_out = !dmem_ack_i && (m_waited == int'(TIMEOUT) - 1);
                if (dmem_ack_i || e.timed_out) begin
                    e.release_now = 1'b1;
                    e.vec = m_pend ? VecFlush : 7'b0;
                end else begin
                    e.vec = VecFreeze;
                end
            end
        end
        return e;
    endfunction

    exp_t e_now;
    always_comb e_now = model_eval();

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_wait   <= 1'b0;
            m_waited <= 0;
            m_pend   <= 1'b0;
            m_err    <= 1'b0;
            m_stall  <= 0;
        end else begin
            if (e_now.vec[6] && m_stall < SatMax) m_stall <= m_stall + 1;
            if (!m_wait) begin
                if (e_now.miss) begin
                    m_wait   <= 1'b1;
                    m_waited <= 0;
                    m_pend   <= branch_taken_i;
                end
            end else if (e_now.release_now) begin
                m_wait <= 1'b0;
                m_pend <= 1'b0;
                if (e_now.timed_out) m_err <= 1'b1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_outputs", int'(dut_vec), int'(e_now.vec));
        check("model_err", int'(err_o), int'(m_err));
        check("model_stall_cnt", int'(stall_cnt_o), m_stall);
    end

    task automatic drive(input logic mr, input logic [4:0] idrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req,
                         input logic ack);
        IDEX_MemRead_i = mr;
        IDEX_RTaddr_i  = idrt;
        IFID_RSaddr_i  = rs;
        IFID_RTaddr_i  = rt;
        branch_taken_i = br;
        dmem_req_i     = req;
        dmem_ack_i     = ack;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_outputs", int'(dut_vec), 0);
        check("reset_err", int'(err_o), 0);
        check("reset_stall_cnt", int'(stall_cnt_o), 0);
        rst_i = 1'b1;
        tick();

        // Load-use on rs: one-cycle interlock
        drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        check("lu_vec", int'(dut_vec), int'(VecLoadUse));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("lu_released", int'(PC_hold_o), 0);
        check("lu_stall_cnt", int'(stall_cnt_o), 1);
        // Load to r0 never interlocks
        drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("lu_r0_no_stall", int'(dut_vec), 0);
        tick();

        // Miss with ack three cycles later
        drive(0, 0, 0, 0, 0, 1, 0);
        check("miss_vec", int'(dut_vec), int'(VecFreeze));
        tick();
        tick();
        check("miss_wait_vec", int'(dut_vec), int'(VecFreeze));
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        check("miss_ack_release", int'(dut_vec), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("miss_stall_cnt", int'(stall_cnt_o), 4);

        // Branch during miss: flush deferred to the ack cycle
        drive(0, 0, 0, 0, 1, 1, 0);
        check("brmiss_no_flush", int'(IFID_flush_o), 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        check("brmiss_wait_no_flush", int'(IFID_flush_o), 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        check("brmiss_ack_flush", int'(dut_vec), int'(VecFlush));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("brmiss_flush_once", int'(IFID_flush_o), 0);
        check("brmiss_stall_cnt", int'(stall_cnt_o), 6);

        // Load-use on rt beats a taken branch
        drive(1, 5'd7, 5'd0, 5'd7, 1, 0, 0);
        check("lu_br_vec", int'(dut_vec), int'(VecLoadUse));
        tick();
        // Same-cycle req+ack is not a stall
        drive(0, 0, 0, 0, 0, 1, 1);
        check("req_ack_quiet", int'(dut_vec), 0);
        tick();
        check("lu_br_stall_cnt", int'(stall_cnt_o), 7);

        // Timeout: four held cycles then a forced release
        drive(0, 0, 0, 0, 0, 1, 0);
        repeat (4) tick();
        check("timeout_release", int'(dut_vec), 0);
        check("timeout_err_not_yet", int'(err_o), 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        check("timeout_err", int'(err_o), 1);
        check("timeout_stall_cnt", int'(stall_cnt_o), 11);
        check("post_timeout_flush", int'(dut_vec), int'(VecFlush));
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        check("err_sticky", int'(err_o), 1);

        // Async reset in the second MEM_WAIT cycle
        drive(0, 0, 0, 0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        check("pre_reset_stall_cnt", int'(stall_cnt_o), 13);
        rst_i = 1'b0;
        #1;
        check("async_rst_outputs", int'(dut_vec), 0);
        check("async_rst_err", int'(err_o), 0);
        check("async_rst_stall_cnt", int'(stall_cnt_o), 0);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        drive(1, 5'd9, 5'd0, 5'd9, 0, 0, 0);
        check("post_rst_lu_vec", int'(dut_vec), int'(VecLoadUse));
        tick();
        check("post_rst_stall_cnt", int'(stall_cnt_o), 1);

        // Counter saturation at all-ones
        repeat (20) tick();
        check("stall_cnt_saturated", int'(stall_cnt_o), SatMax);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Detects load-use hazards between the ID/EX and IF/ID stages.
- Freezes the whole pipeline during multi-cycle data-memory accesses.
- Issues IF/ID flushes for taken branches.
- Drives the hold_i inputs of the PC, IF/ID, ID/EX and EX/MEM registers, plus the bubble-insertion selects, and keeps a stall-cycle performance counter.

Parameters:
TIMEOUT, 255, max MEM_WAIT cycles before forced release and error flag
TO_W, 8, width of timeout counter (must hold TIMEOUT)
PERF_W, 32, width of stall-cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
IDEX_MemRead_i  in  1  instruction in ID/EX is a load
IDEX_RTaddr_i  in  5  load destination register in ID/EX
IFID_RSaddr_i  in  5  rs of instruction in IF/ID
IFID_RTaddr_i  in  5  rt of instruction in IF/ID
branch_taken_i  in  1  ID-stage branch resolved taken
dmem_req_i  in  1  MEM stage starts a data-memory access this cycle
dmem_ack_i  in  1  data memory completes access
PC_hold_o  out  1  freeze PC
IFID_hold_o  out  1  freeze IF/ID
IFID_flush_o  out  1  zero IF/ID instruction at next edge
IDEX_hold_o  out  1  freeze ID/EX
IDEX_bubble_o  out  1  select zero WB/M/EX controls into ID/EX
EXMEM_hold_o  out  1  freeze EX/MEM
MEMWB_bubble_o  out  1  zero MEM/WB controls at next edge
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  PERF_W  cycles with PC_hold_o high, saturating

Behaviour:
- Reset (rst_i low, async): state=RUN; timeout counter=0; pend_flush=0; err_o=0; stall_cnt_o=0; all combinational outputs evaluate to 0 while in reset.
- Terms:
  - lu = IDEX_MemRead_i & (IDEX_RTaddr_i!=0) & (IDEX_RTaddr_i==IFID_RSaddr_i | IDEX_RTaddr_i==IFID_RTaddr_i).
  - miss = dmem_req_i & ~dmem_ack_i.
- Outputs are Mealy (same cycle as the inputs); state updates at the rising edge.
- State RUN:
  - Priority is miss > lu > branch.
  - miss: PC_hold, IFID_hold, IDEX_hold, EXMEM_hold and MEMWB_bubble all 1. Next state MEM_WAIT; timeout counter cleared to 0. If branch_taken_i is also high, pend_flush<=1 and IFID_flush_o=0.
  - else lu: PC_hold=1, IFID_hold=1, IDEX_bubble=1, IDEX_hold=0, IFID_flush=0. The branch is ignored because its operands are unresolved; ID re-evaluates it next cycle. Next state RUN.
  - else branch_taken_i: IFID_flush_o=1, no holds.
  - dmem_req_i & dmem_ack_i in the same cycle: no stall.
- State MEM_WAIT:
  - While dmem_ack_i is low: all four holds=1, MEMWB_bubble=1, IDEX_bubble=0, IFID_flush=0. Timeout counter increments by 1. lu and branch_taken_i are ignored.
  - dmem_ack_i high: all holds=0, MEMWB_bubble=0 (the pipeline advances at this edge), IFID_flush_o=pend_flush. pend_flush<=0; next state RUN.
  - Timeout counter==TIMEOUT-1 with ack low: err_o<=1 (sticky until reset). This cycle behaves as an ack cycle (release, apply pend_flush); next state RUN.
- stall_cnt_o increments by 1 on each edge where PC_hold_o=1. It saturates at all-ones and never wraps.
- IDEX_bubble_o and IDEX_hold_o are never both 1.
- rst_i asserted mid-MEM_WAIT: immediate return to RUN, pend_flush and err_o cleared.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_RT=5, IFID_RS=5 -> PC_hold=IFID_hold=IDEX_bubble=1 for exactly 1 cycle; stall_cnt_o=1. Repeat with IDEX_RT=0 -> no stall.
- Memory miss: dmem_req=1 with ack arriving 3 cycles later -> all holds plus MEMWB_bubble high for 3 cycles, released on the ack cycle; stall_cnt_o=3.
- Branch during miss: branch_taken=1 in the miss cycle, ack after 2 cycles -> IFID_flush_o=0 throughout the wait, then 1 exactly on the ack cycle.
- Simultaneous lu+branch_taken in RUN -> stall asserted, IFID_flush_o=0. Same-cycle req+ack -> no outputs asserted.
- Timeout (TIMEOUT=4): req with no ack -> holds high for 4 cycles, then release; err_o=1 and it stays 1 through later normal traffic.
- Async reset: assert rst_i low in cycle 2 of MEM_WAIT between edges -> outputs drop to 0 immediately. After release, the first lu cycle behaves normally and stall_cnt_o restarts from 0. With PERF_W=4, 20 stall cycles -> stall_cnt_o=15.
